// File: rtl/sdpram_pack.sv
// sdpram_pack -- byte-packing simple dual-port buffer.
//
// Narrow units stream in on the write side through a valid/ready handshake
// and are packed little-endian (lane 0 in the low bits) into wide words.
// The wide side reads any word by address with a one-cycle registered
// latency and frees the oldest committed word on rd_release.
//
// Ports:
//   clk, rst    single rising-edge clock, asynchronous active-high reset
//   wr_valid    narrow unit offered
//   wr_ready    buffer can take a unit (combinational, low during reset)
//   wr_data     narrow unit, INPUT_DATA_W bits
//   wr_clear    synchronous clear of pointer/base/count (memory kept)
//   wr_ptr      next narrow write address
//   rd_en       read request; rd_data is zero after an edge without it
//   rd_addr     wide word address
//   rd_data     registered wide read word
//   rd_release  free the oldest committed word
//   rd_base     word index of the oldest committed word
//   word_count  committed, unreleased words (0..DEPTH)

// One lane of the wide word: a DEPTH x W memory with its own registered
// read port. Memory contents are never reset; only the read register is.
module sdpram_pack_lane #(
  parameter int W     = 8,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read and write share the edge, so a same-word access returns the
  // pre-write content (read-first).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
    else         rdata <= '0;
  end

endmodule

module sdpram_pack #(
  parameter  int INPUT_DATA_W  = 8,
  parameter  int OUTPUT_DATA_W = 32,
  parameter  int SIZE          = 1024,
  localparam int RATIO         = OUTPUT_DATA_W / INPUT_DATA_W,
  localparam int DEPTH         = SIZE * 8 / OUTPUT_DATA_W,
  localparam int NUNITS        = SIZE * 8 / INPUT_DATA_W,
  localparam int WR_ADDR_W     = $clog2(NUNITS),
  localparam int RD_ADDR_W     = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [INPUT_DATA_W-1:0]  wr_data,
  input  logic                     wr_clear,
  output logic [WR_ADDR_W-1:0]     wr_ptr,
  input  logic                     rd_en,
  input  logic [RD_ADDR_W-1:0]     rd_addr,
  output logic [OUTPUT_DATA_W-1:0] rd_data,
  input  logic                     rd_release,
  output logic [RD_ADDR_W-1:0]     rd_base,
  output logic [RD_ADDR_W:0]       word_count
);

  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int CNT_W  = RD_ADDR_W + 1;

  // wr_ptr split into word index and lane, tracked alongside wr_ptr so
  // no divide/modulo is needed when RATIO is not a power of two.
  logic [LANE_W-1:0]    wr_lane;
  logic [RD_ADDR_W-1:0] wr_word;

  logic full, fire, last_lane, commit, release_ok;
  logic [RATIO-1:0][INPUT_DATA_W-1:0] rd_lanes;

  assign full       = (word_count == CNT_W'(DEPTH));
  assign wr_ready   = !rst && !full;
  assign fire       = wr_valid && wr_ready && !wr_clear;
  assign last_lane  = (wr_lane == LANE_W'(RATIO - 1));
  assign commit     = fire && last_lane;
  assign release_ok = rd_release && (word_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      wr_lane    <= '0;
      wr_word    <= '0;
      rd_base    <= '0;
      word_count <= '0;
    end else if (wr_clear) begin
      // Clear wins over a same-cycle fire and release.
      wr_ptr     <= '0;
      wr_lane    <= '0;
      wr_word    <= '0;
      rd_base    <= '0;
      word_count <= '0;
    end else begin
      if (fire) begin
        wr_ptr <= (wr_ptr == WR_ADDR_W'(NUNITS - 1)) ? '0 : wr_ptr + 1'b1;
        if (last_lane) begin
          wr_lane <= '0;
          wr_word <= (wr_word == RD_ADDR_W'(DEPTH - 1)) ? '0 : wr_word + 1'b1;
        end else begin
          wr_lane <= wr_lane + 1'b1;
        end
      end
      if (release_ok)
        rd_base <= (rd_base == RD_ADDR_W'(DEPTH - 1)) ? '0 : rd_base + 1'b1;
      // Commit and release together leave the count unchanged.
      case ({commit, release_ok})
        2'b10:   word_count <= word_count + 1'b1;
        2'b01:   word_count <= word_count - 1'b1;
        default: word_count <= word_count;
      endcase
    end
  end

  for (genvar i = 0; i < RATIO; i++) begin : g_lane
    sdpram_pack_lane #(
      .W     (INPUT_DATA_W),
      .DEPTH (DEPTH),
      .AW    (RD_ADDR_W)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .we    (fire && (wr_lane == LANE_W'(i))),
      .waddr (wr_word),
      .wdata (wr_data),
      .re    (rd_en),
      .raddr (rd_addr),
      .rdata (rd_lanes[i])
    );
  end

  assign rd_data = rd_lanes;

endmodule

// File: tb/tb_sdpram_pack.sv
// Bench for sdpram_pack: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a unit-addressed model.
module tb_sdpram_pack;

  localparam int IW     = 8;
  localparam int OW     = 32;
  localparam int SIZE   = 1024;
  localparam int RATIO  = OW / IW;
  localparam int DEPTH  = SIZE * 8 / OW;
  localparam int NUNITS = SIZE * 8 / IW;
  localparam int WAW    = $clog2(NUNITS);
  localparam int RAW    = $clog2(DEPTH);

  logic           clk = 0;
  logic           rst = 1;
  logic           wr_valid = 0;
  logic           wr_ready;
  logic [IW-1:0]  wr_data = '0;
  logic           wr_clear = 0;
  logic [WAW-1:0] wr_ptr;
  logic           rd_en = 0;
  logic [RAW-1:0] rd_addr = '0;
  logic [OW-1:0]  rd_data;
  logic           rd_release = 0;
  logic [RAW-1:0] rd_base;
  logic [RAW:0]   word_count;

  int tests = 0;
  int errs  = 0;
  bit chk_en = 0;

  sdpram_pack #(.INPUT_DATA_W(IW), .OUTPUT_DATA_W(OW), .SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_clear(wr_clear), .wr_ptr(wr_ptr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_release(rd_release), .rd_base(rd_base), .word_count(word_count)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Memory is a flat array of narrow units; a wide word is just RATIO
  // consecutive units. Units never written are marked unknown and masked.
  logic [IW-1:0] m_mem   [NUNITS];
  bit            m_known [NUNITS];
  int            m_ptr, m_cnt, m_base;
  logic [OW-1:0] m_rd, m_mask;
  logic          m_fire, m_rel, m_commit;

  assign m_fire   = wr_valid && !wr_clear && (m_cnt != DEPTH);
  assign m_rel    = rd_release && (m_cnt != 0);
  assign m_commit = m_fire && ((m_ptr % RATIO) == RATIO - 1);

  function automatic logic [OW-1:0] word_val(input int a);
    logic [OW-1:0] v;
    for (int l = 0; l < RATIO; l++) v[l*IW +: IW] = m_mem[a*RATIO + l];
    return v;
  endfunction

  function automatic logic [OW-1:0] word_mask(input int a);
    logic [OW-1:0] v;
    for (int l = 0; l < RATIO; l++) v[l*IW +: IW] = m_known[a*RATIO + l] ? '1 : '0;
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr  <= 0;
      m_cnt  <= 0;
      m_base <= 0;
      m_rd   <= '0;
      m_mask <= '1;
    end else begin
      m_rd   <= rd_en ? word_val(int'(rd_addr))  : '0;
      m_mask <= rd_en ? word_mask(int'(rd_addr)) : '1;
      if (wr_clear) begin
        m_ptr  <= 0;
        m_cnt  <= 0;
        m_base <= 0;
      end else begin
        if (m_fire) begin
          m_mem[m_ptr]   <= wr_data;
          m_known[m_ptr] <= 1'b1;
          m_ptr          <= (m_ptr + 1) % NUNITS;
        end
        m_cnt <= m_cnt + (m_commit ? 1 : 0) - (m_rel ? 1 : 0);
        if (m_rel) m_base <= (m_base + 1) % DEPTH;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("wr_ptr",     64'(wr_ptr),     64'(m_ptr));
      chk("word_count", 64'(word_count), 64'(m_cnt));
      chk("rd_base",    64'(rd_base),    64'(m_base));
      chk("wr_ready",   64'(wr_ready),   64'(!rst && (m_cnt != DEPTH)));
      chk("rd_data",    64'(rd_data & m_mask), 64'(m_rd & m_mask));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [IW-1:0] d);
    wr_valid = 1;
    wr_data  = d;
    tick();
    wr_valid = 0;
  endtask

  task automatic clear();
    wr_clear = 1;
    tick();
    wr_clear = 0;
  endtask

  initial begin
    logic [7:0] b [4];
    b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;

    // reset
    tick(); tick();
    chk("reset wr_ptr",     64'(wr_ptr), 0);
    chk("reset word_count", 64'(word_count), 0);
    chk("reset rd_data",    64'(rd_data), 0);
    chk("reset wr_ready",   64'(wr_ready), 0);
    rst = 0;
    #1;
    chk_en = 1;
    chk("ready after reset", 64'(wr_ready), 1);

    // first word packs little-endian
    for (int i = 0; i < 4; i++) begin
      push(b[i]);
      chk("pack count", 64'(word_count), (i == 3) ? 1 : 0);
    end
    chk("pack wr_ptr", 64'(wr_ptr), 4);
    rd_en = 1; rd_addr = 0;
    tick();
    rd_en = 0;
    chk("pack rd_data", 64'(rd_data), 64'h44332211);

    // fill to capacity, then one refused unit, then one release
    clear();
    wr_valid = 1;
    for (int i = 0; i < NUNITS; i++) begin
      wr_data = 8'(i) ^ 8'h5A;
      tick();
    end
    chk("full count",    64'(word_count), DEPTH);
    chk("full wr_ready", 64'(wr_ready), 0);
    chk("full wr_ptr",   64'(wr_ptr), 0);
    wr_data = 8'hFF;
    tick();
    wr_valid = 0;
    chk("refused wr_ptr", 64'(wr_ptr), 0);
    chk("refused count",  64'(word_count), DEPTH);
    rd_release = 1;
    tick();
    rd_release = 0;
    chk("release ready", 64'(wr_ready), 1);
    chk("release base",  64'(rd_base), 1);
    chk("release count", 64'(word_count), DEPTH - 1);

    // read-during-write on word 5 lane 3
    clear();
    for (int i = 0; i < 23; i++) push(8'(i + 1));
    wr_valid = 1; wr_data = 8'hAB; rd_en = 1; rd_addr = 5;
    tick();
    wr_valid = 0;
    chk("rdw old lane", 64'(rd_data), 64'h4D171615);
    tick();
    rd_en = 0;
    chk("rdw new lane", 64'(rd_data), 64'hAB171615);

    // commit and release together; release while empty
    clear();
    for (int i = 0; i < 11; i++) push(8'h30 + 8'(i));
    chk("pre coincide count", 64'(word_count), 2);
    wr_valid = 1; wr_data = 8'h3B; rd_release = 1;
    tick();
    wr_valid = 0; rd_release = 0;
    chk("coincide count", 64'(word_count), 2);
    chk("coincide base",  64'(rd_base), 1);
    clear();
    rd_release = 1;
    tick();
    rd_release = 0;
    chk("empty release count", 64'(word_count), 0);
    chk("empty release base",  64'(rd_base), 0);

    // clear beats a same-cycle write
    for (int i = 0; i < 7; i++) push(8'h80 + 8'(i));
    chk("pre clear wr_ptr", 64'(wr_ptr), 7);
    wr_clear = 1; wr_valid = 1; wr_data = 8'hEE;
    tick();
    wr_clear = 0; wr_valid = 0;
    chk("clear wr_ptr", 64'(wr_ptr), 0);
    chk("clear count",  64'(word_count), 0);
    rd_en = 1; rd_addr = 1;
    tick();
    rd_en = 0;
    chk("clear kept mem", 64'(rd_data), 64'h37868584);

    // asynchronous reset between edges
    for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
    rd_en = 1; rd_addr = 1;
    tick();
    rd_en = 0;
    chk("pre reset rd_data", 64'(rd_data), 64'h3786C5C4);
    chk("pre reset wr_ptr",  64'(wr_ptr), 6);
    #2 rst = 1;
    #1;
    chk("async wr_ptr",   64'(wr_ptr), 0);
    chk("async count",    64'(word_count), 0);
    chk("async base",     64'(rd_base), 0);
    chk("async rd_data",  64'(rd_data), 0);
    chk("async wr_ready", 64'(wr_ready), 0);
    tick();
    chk("in reset wr_ready", 64'(wr_ready), 0);
    rst = 0;
    #1;
    chk("post reset wr_ready", 64'(wr_ready), 1);

    // randomized traffic, phases with different release pressure
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 1500; c++) begin
        wr_valid   = ($urandom_range(0, 3) != 0);
        wr_data    = 8'($urandom);
        wr_clear   = ($urandom_range(0, 399) == 0);
        rd_release = (ph[0]) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 15) == 0);
        rd_en      = ($urandom_range(0, 1) == 0);
        rd_addr    = RAW'($urandom);
        tick();
      end
    end
    wr_valid = 0; wr_clear = 0; rd_release = 0; rd_en = 0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule

// File: doc/sdpram_pack.md
Name: sdpram_pack

Overview:
- Simple dual-port byte-packing buffer: narrow streaming write side, wide random-access read side.
- Write side accepts OUTPUT_DATA_W/INPUT_DATA_W narrow units per wide word through a valid/ready handshake, with an auto-incrementing pointer.
- Read side fetches whole wide words and frees the oldest committed word on request.
- Sits upstream of wide consumers (DMA/packet engines) that are fed by byte-serial sources; mirror of the wide-write/narrow-read RAM.

Parameters:
- INPUT_DATA_W, 8, narrow write unit width; multiple of 8.
- OUTPUT_DATA_W, 32, wide read word width; integer multiple of INPUT_DATA_W.
- SIZE, 1024, capacity in bytes.
- Derived: RATIO = OUTPUT_DATA_W/INPUT_DATA_W; DEPTH = SIZE*8/OUTPUT_DATA_W (words); WR_ADDR_W = clog2(SIZE*8/INPUT_DATA_W); RD_ADDR_W = clog2(DEPTH).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wr_valid  in  1  write unit offered.
- wr_ready  out  1  buffer can accept a unit.
- wr_data  in  INPUT_DATA_W  write unit.
- wr_clear  in  1  synchronous pointer/count clear.
- wr_ptr  out  WR_ADDR_W  next narrow write address.
- rd_en  in  1  read request.
- rd_addr  in  RD_ADDR_W  wide word address.
- rd_data  out  OUTPUT_DATA_W  read word, registered.
- rd_release  in  1  free oldest committed word.
- rd_base  out  RD_ADDR_W  word index of oldest committed word.
- word_count  out  RD_ADDR_W+1  committed, unreleased words (0..DEPTH).

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_base=0, word_count=0, rd_data=0. wr_ready is forced 0 while rst is high. Memory contents are not reset.
- wr_ready = !rst && (word_count != DEPTH). This is combinational; it does not depend on wr_valid.
- Write fire = wr_valid && wr_ready && !wr_clear.
  - On fire, wr_data is written to word wr_ptr/RATIO, lane wr_ptr%RATIO. Lane 0 occupies bits [INPUT_DATA_W-1:0] (little-endian packing).
  - wr_ptr then increments and wraps from SIZE*8/INPUT_DATA_W-1 to 0.
- Commit: a fire on lane RATIO-1 completes a word; word_count increments that cycle. Partial words are not counted.
- Release: rd_release && word_count!=0 decrements word_count and increments rd_base, which wraps DEPTH-1 to 0. A release with word_count==0 is ignored.
- Commit and release in the same cycle: word_count is unchanged and rd_base advances.
- wr_clear (synchronous): wr_ptr=0, rd_base=0, word_count=0. It has priority over a same-cycle fire (write dropped, memory untouched) and over release. Memory contents are kept.
- Read:
  - rd_en=1 at edge N gives rd_data = mem[rd_addr] after edge N (1-cycle latency).
  - rd_en=0 at edge N gives rd_data = 0 after edge N.
  - rd_addr is not range-checked against committed words; the reader owns that.
- Read-during-write to the same word is read-first: rd_data shows the old content of the lane being written that cycle.
- Lanes of a word that are still partial read back whatever they last held.
- With RATIO=1, every fire commits.

Test Plan:
- Reset, then 4 fires of bytes 0x11,0x22,0x33,0x44 -> word_count 0,0,0,1; wr_ptr=4; rd_en with rd_addr=0 -> next cycle rd_data=0x44332211.
- 1024 back-to-back fires (DEPTH=256) -> word_count reaches 256, wr_ready=0; the 1025th offered unit is not accepted and wr_ptr holds at 0 (wrapped). One release -> wr_ready=1 next cycle, rd_base=1.
- Write lane 3 of word 5 while reading word 5 the same cycle -> rd_data shows the old lane-3 byte; re-read next cycle shows the new byte.
- Fire on lane 3 coincident with rd_release at word_count=2 -> word_count stays 2, rd_base+1; a release at word_count=0 -> no change.
- wr_clear asserted with wr_valid=1 at wr_ptr=7 -> wr_ptr=0, word_count=0, memory word 1 unchanged on readback.
- Assert rst mid-stream (wr_ptr=6, rd_data nonzero) asynchronously between edges -> all outputs 0 immediately, wr_ready=0 during reset, 1 after release of reset.
